// File: rtl/pkt_arb_mux_8x256.sv
// Packet-level round-robin arbiter and registered data mux: NPORTS streaming sources into one output.
// A source owns the output from its SOP beat through its EOP beat; ownership rotates only at packet boundaries.

module pkt_arb_lane (
    input  logic i_valid,
    input  logic i_sop,
    input  logic i_sel,
    input  logic i_bp_ok,
    output logic o_req,
    output logic o_ready
);
    assign o_req   = i_valid & i_sop;
    assign o_ready = i_sel & i_bp_ok;
endmodule

module pkt_arb_mux_8x256 #(
    parameter int NPORTS = 8,
    parameter int DW     = 256
) (
    input  logic                         iCLK,
    input  logic                         iRST,
    input  logic [NPORTS-1:0]            iVALID,
    input  logic [NPORTS-1:0]            iSOP,
    input  logic [NPORTS-1:0]            iEOP,
    input  logic [NPORTS-1:0][DW-1:0]    iDATA,
    output logic [NPORTS-1:0]            oREADY,
    output logic                         oVALID,
    output logic                         oSOP,
    output logic                         oEOP,
    output logic [DW-1:0]                oDATA,
    output logic [2:0]                   oPORT,
    input  logic                         iREADY,
    output logic                         oSOP_ERR
);
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam logic S_IDLE = 1'b0;
    localparam logic S_XFER = 1'b1;

    logic              r_state;
    logic [2:0]        r_owner;
    logic [2:0]        r_ptr;
    logic              r_first;
    logic              r_err;
    logic              r_valid;
    logic              r_sop;
    logic              r_eop;
    logic [DW-1:0]     r_data;
    logic [2:0]        r_port;

    logic [NPORTS-1:0] w_req;
    logic [NPORTS-1:0] w_sel;
    logic              w_bp_ok;
    logic              w_any;
    logic [2:0]        w_pick;
    logic              w_acc;
    logic [PW-1:0]     w_oidx;
    logic [2:0]        w_ptr_nxt;

    // Output register can take a new beat when empty or draining this cycle.
    assign w_bp_ok   = !r_valid || iREADY;
    assign w_oidx    = r_owner[PW-1:0];
    assign w_acc     = |(iVALID & oREADY);
    assign w_ptr_nxt = (r_owner == 3'(NPORTS-1)) ? 3'd0 : r_owner + 3'd1;

    for (genvar g = 0; g < NPORTS; g++) begin : g_lane
        assign w_sel[g] = (r_state == S_XFER) && (r_owner == 3'(g));
        pkt_arb_lane u_lane (
            .i_valid (iVALID[g]),
            .i_sop   (iSOP[g]),
            .i_sel   (w_sel[g]),
            .i_bp_ok (w_bp_ok),
            .o_req   (w_req[g]),
            .o_ready (oREADY[g])
        );
    end

    // First requester at or after r_ptr, searching upward with wrap.
    always_comb begin
        int j;
        w_any  = 1'b0;
        w_pick = '0;
        for (int k = 0; k < NPORTS; k++) begin
            j = int'(r_ptr) + k;
            if (j >= NPORTS) j = j - NPORTS;
            if (!w_any && w_req[j]) begin
                w_any  = 1'b1;
                w_pick = 3'(j);
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_first <= 1'b0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_data  <= '0;
            r_port  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_any) begin
                    r_owner <= w_pick;
                    r_first <= 1'b1;
                    r_state <= S_XFER;
                end
                default: if (w_acc) begin
                    r_first <= 1'b0;
                    if (iSOP[w_oidx] && !r_first) r_err <= 1'b1;
                    if (iEOP[w_oidx]) begin
                        r_ptr   <= w_ptr_nxt;
                        r_state <= S_IDLE;
                    end
                end
            endcase
            if (w_acc) begin
                r_valid <= 1'b1;
                r_sop   <= iSOP[w_oidx];
                r_eop   <= iEOP[w_oidx];
                r_data  <= iDATA[w_oidx];
                r_port  <= r_owner;
            end else if (iREADY) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign oVALID   = r_valid;
    assign oSOP     = r_sop;
    assign oEOP     = r_eop;
    assign oDATA    = r_data;
    assign oPORT    = r_port;
    assign oSOP_ERR = r_err;
endmodule

// File: tb/tb_pkt_arb_mux_8x256.sv
// Bench for pkt_arb_mux_8x256: queue-driven sources, output beat log, and a packet-level round-robin model.
module tb_pkt_arb_mux_8x256;
    localparam int NP = 8;
    localparam int DW = 256;

    logic                   iCLK = 1'b0;
    logic                   iRST;
    logic [NP-1:0]          iVALID, iSOP, iEOP;
    logic [NP-1:0][DW-1:0]  iDATA;
    logic [NP-1:0]          oREADY;
    logic                   oVALID, oSOP, oEOP;
    logic [DW-1:0]          oDATA;
    logic [2:0]             oPORT;
    logic                   iREADY;
    logic                   oSOP_ERR;

    pkt_arb_mux_8x256 #(.NPORTS(NP), .DW(DW)) dut (
        .iCLK(iCLK), .iRST(iRST), .iVALID(iVALID), .iSOP(iSOP), .iEOP(iEOP), .iDATA(iDATA),
        .oREADY(oREADY), .oVALID(oVALID), .oSOP(oSOP), .oEOP(oEOP), .oDATA(oDATA),
        .oPORT(oPORT), .iREADY(iREADY), .oSOP_ERR(oSOP_ERR)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
        logic [2:0]    port;
        int            cyc;
    } beat_t;

    beat_t src_q[NP][$];
    beat_t exp_q[NP][$];
    beat_t obs[$];
    logic  rdy_script[$];
    int    hold[NP];
    int    gap_pct = 0, rdy_pct = 100;
    int    cyc = 0, n_chk = 0, n_fail = 0, bp_viol = 0, hold_viol = 0;
    logic          prev_stall = 1'b0;
    logic [DW+4:0] prev_out;

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() > 0 && hold[p] == 0 &&
                (src_q[p][0].sop || $urandom_range(99) >= gap_pct)) begin
                iVALID[p] = 1'b1;
                iSOP[p]   = src_q[p][0].sop;
                iEOP[p]   = src_q[p][0].eop;
                iDATA[p]  = src_q[p][0].d;
            end else begin
                iVALID[p] = 1'b0;
                iSOP[p]   = 1'b0;
                iEOP[p]   = 1'b0;
                iDATA[p]  = '0;
            end
        end
    endtask

    task automatic step();
        logic [NP-1:0] acc;
        beat_t b;
        @(negedge iCLK);
        acc = iVALID & oREADY;
        if (oVALID && !iREADY && oREADY != '0) bp_viol++;
        if (prev_stall && !iRST && (!oVALID || {oDATA, oSOP, oEOP, oPORT} != prev_out)) hold_viol++;
        prev_stall = oVALID && !iREADY && !iRST;
        prev_out   = {oDATA, oSOP, oEOP, oPORT};
        if (oVALID && iREADY) begin
            b.d = oDATA; b.sop = oSOP; b.eop = oEOP; b.port = oPORT; b.cyc = cyc;
            obs.push_back(b);
        end
        @(posedge iCLK);
        #1;
        cyc++;
        for (int p = 0; p < NP; p++) begin
            if (acc[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
            if (hold[p] > 0) hold[p]--;
        end
        if (rdy_script.size() > 0) iREADY = rdy_script.pop_front();
        else iREADY = ($urandom_range(99) < rdy_pct);
        drive();
    endtask

    task automatic enq(input int p, input int n, input int sop2);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = rnd_data(); b.sop = (i == 0) || (i == sop2); b.eop = (i == n-1);
            b.port = 3'(p); b.cyc = 0;
            src_q[p].push_back(b);
            exp_q[p].push_back(b);
        end
        drive();
    endtask

    task automatic apply_reset();
        iRST = 1'b1;
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete(); exp_q[p].delete(); hold[p] = 0;
        end
        obs.delete(); rdy_script.delete();
        drive();
        step(); step();
        iRST = 1'b0;
        prev_stall = 1'b0;
    endtask

    task automatic test_reset();
        iRST = 1'b0; iVALID = '0; iSOP = '0; iEOP = '0; iDATA = '0; iREADY = 1'b1;
        for (int p = 0; p < NP; p++) hold[p] = 0;
        #2 iRST = 1'b1;
        #1;
        n_chk++;
        if ({oVALID, oSOP, oEOP, oPORT, oREADY, oSOP_ERR} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got v=%b s=%b e=%b port=%0d rdy=%b err=%b, expected all 0",
                     oVALID, oSOP, oEOP, oPORT, oREADY, oSOP_ERR);
        end
        n_chk++;
        if (oDATA !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", oDATA); end
        step(); step();
        iRST = 1'b0;
        repeat (3) step();
        n_chk++;
        if (obs.size() != 0 || oREADY !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: got %0d beats, oREADY=%b expected 0 beats, oREADY=0", obs.size(), oREADY);
        end
    endtask

    task automatic test_single_source();
        int c0;
        c0 = cyc;
        enq(3, 4, -1);
        for (int t = 0; t < 20 && obs.size() < 4; t++) step();
        n_chk++;
        if (obs.size() != 4) begin n_fail++; $display("FAIL single_count: got %0d beats expected 4", obs.size()); end
        for (int i = 0; i < obs.size() && i < 4; i++) begin
            n_chk++;
            if (obs[i].port !== 3'd3 || obs[i].d !== exp_q[3][i].d || obs[i].sop !== (i == 0) ||
                obs[i].eop !== (i == 3) || obs[i].cyc != c0 + 2 + i) begin
                n_fail++;
                $display("FAIL single_beat%0d: got port=%0d sop=%b eop=%b cyc=%0d, expected port=3 sop=%b eop=%b cyc=%0d",
                         i, obs[i].port, obs[i].sop, obs[i].eop, obs[i].cyc, i == 0, i == 3, c0 + 2 + i);
            end
        end
        exp_q[3].delete(); obs.delete();
        repeat (2) step();
    endtask

    task automatic test_fairness();
        apply_reset();
        for (int p = 0; p < NP; p++) begin enq(p, 2, -1); enq(p, 2, -1); end
        for (int t = 0; t < 200 && obs.size() < 32; t++) step();
        n_chk++;
        if (obs.size() != 32) begin n_fail++; $display("FAIL fair_count: got %0d beats expected 32", obs.size()); end
        if (obs.size() >= 32) begin
            for (int k = 0; k < 16; k++) begin
                beat_t b0, b1, e0, e1;
                int wp;
                wp = k % NP;
                b0 = obs[2*k]; b1 = obs[2*k+1];
                e0 = exp_q[wp].pop_front(); e1 = exp_q[wp].pop_front();
                n_chk++;
                if (b0.port !== 3'(wp) || b1.port !== 3'(wp) || b0.d !== e0.d || b1.d !== e1.d ||
                    !b0.sop || b0.eop || b1.sop || !b1.eop) begin
                    n_fail++;
                    $display("FAIL fair_pkt%0d: got port %0d/%0d expected %0d (or data/sop/eop wrong)",
                             k, b0.port, b1.port, wp);
                end
                if (k > 0) begin
                    n_chk++;
                    if (b0.cyc != obs[2*k-1].cyc + 2 || b1.cyc != b0.cyc + 1) begin
                        n_fail++;
                        $display("FAIL fair_gap%0d: sop at %0d after eop at %0d, expected gap of 2",
                                 k, b0.cyc, obs[2*k-1].cyc);
                    end
                end
            end
        end
        obs.delete();
    endtask

    task automatic test_backpressure();
        int c0;
        c0 = cyc;
        bp_viol = 0; hold_viol = 0;
        enq(5, 3, -1);
        rdy_script = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int t = 0; t < 30 && obs.size() < 3; t++) step();
        repeat (4) step();
        n_chk++;
        if (obs.size() != 3) begin n_fail++; $display("FAIL bp_count: got %0d beats expected 3", obs.size()); end
        for (int i = 0; i < obs.size() && i < 3; i++) begin
            int wc;
            wc = (i == 0) ? c0 + 2 : c0 + 4 + i;
            n_chk++;
            if (obs[i].port !== 3'd5 || obs[i].d !== exp_q[5][i].d || obs[i].cyc != wc) begin
                n_fail++;
                $display("FAIL bp_beat%0d: got port=%0d cyc=%0d expected port=5 cyc=%0d (or data wrong)",
                         i, obs[i].port, obs[i].cyc, wc);
            end
        end
        n_chk++;
        if (bp_viol != 0) begin n_fail++; $display("FAIL bp_ready: got %0d stalled cycles with oREADY set, expected 0", bp_viol); end
        n_chk++;
        if (hold_viol != 0) begin n_fail++; $display("FAIL bp_hold: got %0d output changes under stall, expected 0", hold_viol); end
        exp_q[5].delete(); obs.delete();
    endtask

    task automatic test_single_beat_stall();
        int g2;
        g2 = 0;
        enq(0, 1, -1);
        repeat (6) step();
        n_chk++;
        if (obs.size() != 1 || obs[0].port !== 3'd0 || !obs[0].sop || !obs[0].eop || obs[0].d !== exp_q[0][0].d) begin
            n_fail++;
            $display("FAIL sbeat_out: got %0d beats, expected exactly 1 sop+eop beat from port 0", obs.size());
        end
        n_chk++;
        if (oREADY !== '0) begin n_fail++; $display("FAIL sbeat_idle: got oREADY=%b expected 0", oREADY); end
        exp_q[0].delete(); obs.delete();
        enq(1, 4, -1);
        enq(2, 2, -1);
        for (int t = 0; t < 10 && src_q[1].size() > 3; t++) step();
        hold[1] = 5;
        drive();
        repeat (5) begin
            step();
            g2 += int'(oREADY[2]);
        end
        n_chk++;
        if (oREADY !== 8'b0000_0010) begin n_fail++; $display("FAIL stall_owner: got oREADY=%b expected 00000010", oREADY); end
        for (int t = 0; t < 60 && obs.size() < 6; t++) begin
            step();
            if (src_q[1].size() > 0) g2 += int'(oREADY[2]);
        end
        n_chk++;
        if (g2 != 0) begin n_fail++; $display("FAIL stall_nogrant: got %0d port-2 ready cycles during port-1 packet, expected 0", g2); end
        n_chk++;
        if (obs.size() != 6) begin n_fail++; $display("FAIL stall_count: got %0d beats expected 6", obs.size()); end
        for (int i = 0; i < obs.size() && i < 6; i++) begin
            int wp;
            beat_t e;
            wp = (i < 4) ? 1 : 2;
            e = exp_q[wp][(i < 4) ? i : i - 4];
            n_chk++;
            if (obs[i].port !== 3'(wp) || obs[i].d !== e.d || obs[i].sop !== e.sop || obs[i].eop !== e.eop) begin
                n_fail++;
                $display("FAIL stall_beat%0d: got port=%0d expected port=%0d (or data wrong)", i, obs[i].port, wp);
            end
        end
        exp_q[1].delete(); exp_q[2].delete(); obs.delete();
    endtask

    task automatic test_sop_err_reset();
        enq(2, 5, 2);
        for (int t = 0; t < 20 && obs.size() < 1; t++) step();
        n_chk++;
        if (oSOP_ERR !== 1'b0) begin n_fail++; $display("FAIL err_early: got %b expected 0", oSOP_ERR); end
        for (int t = 0; t < 20 && obs.size() < 5; t++) step();
        repeat (3) step();
        n_chk++;
        if (oSOP_ERR !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", oSOP_ERR); end
        n_chk++;
        if (obs.size() != 5 || !obs[2].sop || obs[2].d !== exp_q[2][2].d || obs[2].port !== 3'd2) begin
            n_fail++;
            $display("FAIL err_fwd: got %0d beats, beat2 sop not forwarded unchanged", obs.size());
        end
        exp_q[2].delete(); obs.delete();
        enq(6, 6, -1);
        for (int t = 0; t < 20 && obs.size() < 2; t++) step();
        iRST = 1'b1;
        #1;
        n_chk++;
        if ({oVALID, oSOP, oEOP, oPORT, oREADY, oSOP_ERR} !== '0 || oDATA !== '0) begin
            n_fail++;
            $display("FAIL midrst: got v=%b s=%b e=%b port=%0d rdy=%b err=%b, expected all 0",
                     oVALID, oSOP, oEOP, oPORT, oREADY, oSOP_ERR);
        end
        for (int p = 0; p < NP; p++) begin src_q[p].delete(); exp_q[p].delete(); end
        drive();
        step(); step();
        iRST = 1'b0;
        prev_stall = 1'b0;
        obs.delete();
        enq(7, 2, -1);
        enq(0, 2, -1);
        for (int t = 0; t < 30 && obs.size() < 4; t++) step();
        n_chk++;
        if (obs.size() != 4 || obs[0].port !== 3'd0 || obs[2].port !== 3'd7) begin
            n_fail++;
            $display("FAIL rst_ptr: got %0d beats, first port %0d, expected port 0 then 7",
                     obs.size(), (obs.size() > 0) ? int'(obs[0].port) : -1);
        end
        obs.delete();
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            int rem[NP];
            int total, mptr, cur;
            bit inpkt;
            apply_reset();
            gap_pct = 25; rdy_pct = 60;
            total = 0;
            for (int p = 0; p < NP; p++) begin
                rem[p] = $urandom_range(3);
                for (int k = 0; k < rem[p]; k++) begin
                    int n;
                    n = $urandom_range(1, 4);
                    enq(p, n, -1);
                    total += n;
                end
            end
            for (int t = 0; t < 3000 && obs.size() < total; t++) step();
            repeat (4) step();
            n_chk++;
            if (obs.size() != total) begin
                n_fail++;
                $display("FAIL rand_count: round %0d got %0d beats expected %0d", r, obs.size(), total);
            end
            mptr = 0; inpkt = 0; cur = 0;
            for (int i = 0; i < obs.size(); i++) begin
                int p, want;
                beat_t e;
                p = int'(obs[i].port);
                if (!inpkt) begin
                    want = -1;
                    for (int k = 0; k < NP; k++)
                        if (want < 0 && rem[(mptr + k) % NP] > 0) want = (mptr + k) % NP;
                    n_chk++;
                    if (p != want) begin n_fail++; $display("FAIL rand_grant: beat %0d got port %0d expected %0d", i, p, want); end
                    if (p < NP && rem[p] > 0) rem[p]--;
                    cur = p; inpkt = 1;
                end else begin
                    n_chk++;
                    if (p != cur) begin n_fail++; $display("FAIL rand_interleave: beat %0d got port %0d expected %0d", i, p, cur); end
                end
                n_chk++;
                if (p >= NP || exp_q[p].size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra: beat %0d from port %0d, expected none", i, p);
                end else begin
                    e = exp_q[p].pop_front();
                    if (obs[i].d !== e.d || obs[i].sop !== e.sop || obs[i].eop !== e.eop) begin
                        n_fail++;
                        $display("FAIL rand_data: beat %0d port %0d got sop=%b eop=%b expected sop=%b eop=%b (or data)",
                                 i, p, obs[i].sop, obs[i].eop, e.sop, e.eop);
                    end
                end
                if (obs[i].eop) begin inpkt = 0; mptr = (p + 1) % NP; end
            end
            n_chk++;
            if (bp_viol != 0 || hold_viol != 0) begin
                n_fail++;
                $display("FAIL rand_bp: got %0d ready and %0d hold violations, expected 0", bp_viol, hold_viol);
            end
        end
        gap_pct = 0; rdy_pct = 100;
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_fairness();
        test_backpressure();
        test_single_beat_stall();
        test_sop_err_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pkt_arb_mux_8x256.md
# pkt_arb_mux_8x256

Packet-level arbiter and data mux that merges up to eight 256-bit streaming sources into one registered output stream toward the PCIe TX path. A source owns the output from its SOP beat through its EOP beat. Ownership rotates round-robin at packet boundaries so no source is starved. Packet data is never interleaved between sources.

## Interface
- NPORTS, 8, number of source ports; legal range 2–8.
- DW, 256, data width in bits.
- iCLK  in  1  clock; all logic on rising edge.
- iRST  in  1  reset, asynchronous, active-high.
- iVALID  in  NPORTS  per-port beat valid.
- iSOP  in  NPORTS  per-port first beat of packet.
- iEOP  in  NPORTS  per-port last beat of packet.
- iDATA  in  NPORTS×DW  per-port beat data; packed array [NPORTS-1:0][DW-1:0].
- oREADY  out  NPORTS  per-port beat accept.
- oVALID  out  1  output beat valid.
- oSOP  out  1  output first beat.
- oEOP  out  1  output last beat.
- oDATA  out  DW  output beat data.
- oPORT  out  3  source index of the current output beat.
- iREADY  in  1  downstream accept.
- oSOP_ERR  out  1  sticky protocol error flag; cleared only by iRST.

## Operation
- Beat transfer rule: an input beat moves when iVALID[i]=1 and oREADY[i]=1. An output beat moves when oVALID=1 and iREADY=1.
- Request rule: port i requests when iVALID[i]=1 and iSOP[i]=1. A valid beat without SOP is not a request and is not accepted while in IDLE.
- The FSM has two states, IDLE and XFER.
- IDLE:
  - If any port requests, pick the first requester at or after the priority pointer `ptr`, searching upward with wrap.
  - Register that port as `owner` and go to XFER.
  - All oREADY bits are 0 in IDLE.
- XFER:
  - oREADY[owner] = (!oVALID || iREADY). All other oREADY bits are 0.
  - On each accepted beat, the output register loads iDATA[owner], iSOP[owner], iEOP[owner], and oPORT=owner, and sets oVALID=1.
  - On an accepted beat with iEOP[owner]=1, set ptr = (owner+1) mod NPORTS and go to IDLE.
- Output register:
  - If it is not reloaded and iREADY=1, oVALID clears.
  - While oVALID=1 and iREADY=0, oDATA, oSOP, oEOP and oPORT hold stable.
- Owner stall: if the owner drops iVALID mid-packet, the FSM stays in XFER. No timeout and no re-arbitration.
- Single-beat packet (iSOP=iEOP=1): accepted in one XFER cycle, then IDLE.
- SOP error: an accepted owner beat with iSOP=1 that is not the first beat of the packet sets oSOP_ERR=1. The beat is still forwarded unchanged.
- Port width: ports at index ≥ NPORTS do not exist. oPORT upper bits are 0 when NPORTS<8.

## Timing
- Reset values: oVALID=0, oSOP=0, oEOP=0, oDATA=0, oPORT=0, oREADY=0, oSOP_ERR=0, ptr=0, FSM=IDLE.
- An iRST assertion mid-packet aborts the packet immediately. No partial-packet recovery.
- Arbitration latency:
  - SOP valid at a port in IDLE during cycle N → owner is registered at edge N.
  - oREADY[owner]=1 during cycle N+1.
  - With iREADY=1, the first beat appears on oVALID in cycle N+2.
- Throughput: one beat per cycle within a packet while iREADY=1.
- Packet boundary bubble: there is exactly one IDLE cycle between the EOP acceptance of one packet and the SOP acceptance of the next.
- Backpressure: oREADY[owner] is combinational from oVALID and iREADY. There is no other combinational path from inputs to outputs.
- The request decision uses ptr as registered before the cycle. ptr updates on the EOP-accept edge.

## Test plan
- Single source: port 3 sends 4 beats (SOP on D0, EOP on D3), iREADY=1 → oVALID for 4 consecutive cycles starting 2 cycles after SOP. oPORT=3. oSOP on beat 0 only, oEOP on beat 3 only. Data matches in order.
- Fairness: all 8 ports continuously offer 2-beat packets → output packet order is 0,1,2,…,7,0. Each packet is separated by exactly one idle cycle.
- Backpressure: iREADY toggles 1,0,0,1 during a 3-beat packet from port 5 → no beat lost or duplicated. oDATA holds while iREADY=0. oREADY[5]=0 whenever oVALID=1 and iREADY=0.
- Single-beat and stall: port 0 sends a single-beat packet (SOP=EOP=1) → exactly 1 beat out, then IDLE. Port 1 drops iVALID for 5 cycles mid-packet → the FSM stays with owner 1 and other requesters get no grant until port 1 sends EOP.
- Error and reset: port 2 sends SOP on beat 2 of a packet → oSOP_ERR rises and stays high. Assert iRST mid-packet → all outputs return to reset values asynchronously, ptr=0, and the next arbitration favours port 0.
